// File: rtl/five_bit_serial_subtractor.sv
// Bit-serial 5-bit unsigned subtractor (D = A - B, LSB first, one bit per clock).
// Optional macro SUB_SATURATE_EN clamps D to 0 whenever the result borrows.
//
// state | meaning
// IDLE  | waiting for start; D/borrow hold the last result
// RUN   | shifting one bit per cycle, bit counter 0..4
// DONE  | one-cycle done pulse; D/borrow already hold the new result
module five_bit_serial_subtractor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] A,
  input  logic [4:0] B,
  output logic       busy,
  output logic       done,
  output logic [4:0] D,
  output logic       borrow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, stateNext;
  logic [4:0] aSh, bSh, dSh;
  logic       bw;
  logic [2:0] bitCnt;
  logic       aBit, bBit, dBit, bwNext, lastBit;
  logic [4:0] diff;

  assign aBit    = aSh[0];
  assign bBit    = bSh[0];
  assign dBit    = aBit ^ bBit ^ bw;
  assign bwNext  = (~aBit & bBit) | (~(aBit ^ bBit) & bw);
  assign diff    = {dBit, dSh[4:1]};
  assign lastBit = (bitCnt == 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) stateNext = RUN;
      RUN: begin
        busy = 1'b1;
        if (lastBit) stateNext = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: the result registers load only on the bit-4 edge, so they stay stable through RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aSh    <= '0;
      bSh    <= '0;
      dSh    <= '0;
      bw     <= 1'b0;
      bitCnt <= '0;
      D      <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aSh    <= A;
            bSh    <= B;
            dSh    <= '0;
            bw     <= 1'b0;
            bitCnt <= '0;
          end
        end
        RUN: begin
          aSh    <= aSh >> 1;
          bSh    <= bSh >> 1;
          dSh    <= diff;
          bw     <= bwNext;
          bitCnt <= bitCnt + 3'd1;
          if (lastBit) begin
            borrow <= bwNext;
`ifdef SUB_SATURATE_EN
            D      <= bwNext ? 5'd0 : diff;
`else
            D      <= diff;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_five_bit_serial_subtractor.sv
// Scoreboard bench for five_bit_serial_subtractor: directed vectors push expected
// {D,borrow} into a queue; an independent monitor pops and compares on each done pulse.
module tb_five_bit_serial_subtractor;

`ifdef SUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] A = '0;
  logic [4:0] B = '0;
  logic       busy, done, borrow;
  logic [4:0] D;

  int errors = 0;
  int checks = 0;
  logic [5:0] expQ[$];
  logic [4:0] lastD = '0;

  five_bit_serial_subtractor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .D(D), .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [5:0] e;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got D=%0d borrow=%0d with no operation pending", D, borrow);
      end else begin
        e = expQ.pop_front();
        if ({D, borrow} != e) begin
          errors++;
          $display("FAIL result: got D=%0d borrow=%0d expected D=%0d borrow=%0d",
                   D, borrow, e[5:1], e[0]);
        end
      end
    end
  end

  // Called at a negedge; drives one start pulse and checks latency, busy width and hold.
  task automatic runOp(input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] expD, input logic expBw, input bit scramble);
    int lat, busyCnt;
    A = a; B = b; start = 1'b1;
    expQ.push_back({expD, expBw});
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      A = ~a; B = ~b;
    end
    lat = 1;
    busyCnt = busy ? 1 : 0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      if (busy) busyCnt++;
      if (lat == 3) chk("d_hold_during_run", D, lastD);
    end
    chk("done_latency", lat, 6);
    chk("busy_cycles", busyCnt, 6);
    lastD = expD;
    @(negedge clk);
    chk("idle_after_done", {busy, done}, 0);
  endtask

  initial begin
    int cyc, prevCyc, w;
    #1;
    chk("reset_D", D, 0);
    chk("reset_borrow", borrow, 0);
    chk("reset_busy_done", {busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    runOp(5'd13, 5'd6,  5'd7,                     1'b0, 0);
    runOp(5'd6,  5'd13, SAT ? 5'd0 : 5'd25,       1'b1, 0);
    runOp(5'd0,  5'd1,  SAT ? 5'd0 : 5'd31,       1'b1, 0);
    runOp(5'd31, 5'd31, 5'd0,                     1'b0, 0);
    runOp(5'd10, 5'd3,  5'd7,                     1'b0, 1);

    // start held high: one result every 7 cycles, no extra pulses
    A = 5'd20; B = 5'd4; start = 1'b1;
    repeat (3) expQ.push_back({5'd16, 1'b0});
    cyc = 0; prevCyc = 0;
    for (int n = 0; n < 3; n++) begin
      w = 0;
      do begin
        @(negedge clk);
        cyc++; w++;
      end while (!done && w < 12);
      chk("held_start_done_seen", done, 1);
      if (n > 0) chk("held_start_period", cyc - prevCyc, 7);
      prevCyc = cyc;
    end
    start = 1'b0;
    lastD = 5'd16;
    repeat (12) @(negedge clk);
    chk("held_start_queue_drained", expQ.size(), 0);

    // reset while bit 2 is about to be processed
    A = 5'd25; B = 5'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_D", D, 0);
    chk("abort_borrow", borrow, 0);
    chk("abort_busy_done", {busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    lastD = 5'd0;
    runOp(5'd9, 5'd3, 5'd6, 1'b0, 0);

    repeat (10) @(negedge clk);
    chk("queue_empty_at_end", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
